// File: rtl/digit_entry_if.sv
// digit_entry_if: button, preset and committed-value signals of the digit entry editor
interface digit_entry_if;
    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic load;
    logic [19:0] load_value;
    logic [19:0] value;
    logic [2:0] cursor;
    logic value_valid;
    logic changed;
    modport master (
        output btn_up, btn_down, btn_left, btn_right, load, load_value,
        input value, cursor, value_valid, changed
    );
    modport slave (
        input btn_up, btn_down, btn_left, btn_right, load, load_value,
        output value, cursor, value_valid, changed
    );
endinterface

// File: rtl/digit_entry_editor.sv
// digit_entry_editor: debounced push-button editor of a 6-digit decimal value with ceiling check and preset load
module digit_entry_editor #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE = 10_000_000,
    parameter int MAX_VALUE = 999_999,
    parameter int RESET_VALUE = 1000
) (
    input logic clk,
    input logic rst,
    digit_entry_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RP_FIRE = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [19:0] MAXV = 20'(MAX_VALUE);

    function automatic logic [23:0] to_bcd(int v);
        logic [23:0] r;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [23:0] RESET_BCD = to_bcd(RESET_VALUE);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t state;
    logic [3:0] raw, s1, s2, db, db_q, press;
    logic [DW-1:0] dcnt [4];
    logic [RW-1:0] rcnt [2];
    logic [1:0] rep;
    logic ev_up, ev_down;
    logic [5:0][3:0] dig, cand, adj;
    logic [3:0] cur_d, nxt_d;
    logic [19:0] acc, bin, lv, value;
    logic [4:0] step;
    logic [2:0] cursor;
    logic value_valid, changed;

    // bit order: 0 up, 1 down, 2 left, 3 right
    assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign press = db & ~db_q;
    assign rep = {db[1] && rcnt[1] == RP_FIRE, db[0] && rcnt[0] == RP_FIRE};
    assign ev_up = press[0] | rep[0];
    assign ev_down = press[1] | rep[1];
    assign cur_d = dig[cursor];
    assign nxt_d = ev_up ? (cur_d == 4'd9 ? 4'd0 : cur_d + 4'd1) : (cur_d == 4'd0 ? 4'd9 : cur_d - 4'd1);
    assign lv = bus.load_value > MAXV ? MAXV : bus.load_value;

    for (genvar j = 0; j < 6; j++) begin : g_adj
        assign adj[j] = cand[j] >= 4'd5 ? cand[j] + 4'd3 : cand[j];
    end

    assign bus.value = value;
    assign bus.cursor = cursor;
    assign bus.value_valid = value_valid;
    assign bus.changed = changed;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            db_q <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            db_q <= db;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DB_LAST) begin
                    dcnt[i] <= '0;
                    db[i] <= s2[i];
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
            // after the first repeat, reload so the next one lands REPEAT_RATE later
            for (int i = 0; i < 2; i++)
                rcnt[i] <= !db[i] ? '0 : rep[i] ? RP_RELOAD : rcnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            value <= 20'(RESET_VALUE);
            dig <= RESET_BCD;
            cand <= '0;
            cursor <= '0;
            value_valid <= 1'b1;
            changed <= 1'b0;
            acc <= '0;
            bin <= '0;
            step <= '0;
        end else begin
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        acc <= lv;
                        bin <= lv;
                        cand <= '0;
                        step <= '0;
                        value_valid <= 1'b0;
                        state <= LOAD;
                    end else if (ev_up || ev_down) begin
                        cand <= dig;
                        cand[cursor] <= nxt_d;
                        acc <= '0;
                        step <= '0;
                        value_valid <= 1'b0;
                        state <= CONV;
                    end else if (press[2]) cursor <= cursor == 3'd5 ? 3'd0 : cursor + 3'd1;
                    else if (press[3]) cursor <= cursor == 3'd0 ? 3'd5 : cursor - 3'd1;
                end
                CONV: begin
                    if (step == 5'd6) begin
                        if (acc <= MAXV) begin
                            value <= acc;
                            dig <= cand;
                            changed <= 1'b1;
                        end
                        value_valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        acc <= acc * 20'd10 + 20'(cand[3'(3'd5 - step[2:0])]);
                        step <= step + 5'd1;
                    end
                end
                LOAD: begin
                    // acc holds the clamped preset while cand accumulates its BCD form
                    if (step == 5'd20) begin
                        value <= acc;
                        dig <= cand;
                        changed <= 1'b1;
                        value_valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        {cand, bin} <= {adj, bin} << 1;
                        step <= step + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_entry_editor.sv
// tb_digit_entry_editor: cycle-level reference model bench for the digit entry editor
module tb_digit_entry_editor;
    localparam int D = 4, RD = 20, RR = 8, MAXV = 500_000, RSTV = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    int chg_total = 0;
    bit started = 0;

    always #5 clk = ~clk;

    digit_entry_if bus();

    digit_entry_editor #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
        .MAX_VALUE(MAXV), .RESET_VALUE(RSTV)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    int hist[4][8];
    int db[4], dbq[4], hold[4], ev[4], raw[4];
    int m_val, m_cur, m_busy, m_pval, mv;
    int m_dig[6], m_pdig[6];
    bit m_ok, m_chg, m_valid, all_diff;

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: debounced level flips once the synchronized input has disagreed with it for D cycles
    always @(posedge clk) begin
        raw[0] = int'(bus.btn_up);
        raw[1] = int'(bus.btn_down);
        raw[2] = int'(bus.btn_left);
        raw[3] = int'(bus.btn_right);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                db[i] = 0;
                dbq[i] = 0;
                hold[i] = 0;
                for (int j = 0; j < 8; j++) hist[i][j] = 0;
            end
            m_val = RSTV;
            mv = RSTV;
            for (int k = 0; k < 6; k++) begin
                m_dig[k] = mv % 10;
                mv = mv / 10;
            end
            m_cur = 0;
            m_busy = 0;
            m_valid = 1;
            m_chg = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ev[i] = (db[i] != 0 && dbq[i] == 0) ? 1 : 0;
                if (ev[i] != 0) hold[i] = 0;
                else if (db[i] != 0) hold[i]++;
                if (i < 2 && db[i] != 0 && hold[i] >= RD && (hold[i] - RD) % RR == 0) ev[i] = 1;
            end
            m_chg = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (m_ok) begin
                        m_val = m_pval;
                        for (int k = 0; k < 6; k++) m_dig[k] = m_pdig[k];
                        m_chg = 1;
                    end
                    m_valid = 1;
                end
            end else if (bus.load) begin
                mv = int'(bus.load_value) > MAXV ? MAXV : int'(bus.load_value);
                m_pval = mv;
                for (int k = 0; k < 6; k++) begin
                    m_pdig[k] = mv % 10;
                    mv = mv / 10;
                end
                m_ok = 1;
                m_busy = 21;
                m_valid = 0;
            end else if (ev[0] != 0 || ev[1] != 0) begin
                for (int k = 0; k < 6; k++) m_pdig[k] = m_dig[k];
                m_pdig[m_cur] = ev[0] != 0 ? (m_dig[m_cur] + 1) % 10 : (m_dig[m_cur] + 9) % 10;
                m_pval = 0;
                for (int k = 5; k >= 0; k--) m_pval = m_pval * 10 + m_pdig[k];
                m_ok = m_pval <= MAXV;
                m_busy = 7;
                m_valid = 0;
            end else if (ev[2] != 0) m_cur = (m_cur + 1) % 6;
            else if (ev[3] != 0) m_cur = (m_cur + 5) % 6;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1;
                for (int j = 1; j <= D; j++) if (hist[i][j] == db[i]) all_diff = 0;
                dbq[i] = db[i];
                if (all_diff) db[i] = 1 - db[i];
                for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = raw[i];
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("value", int'(bus.value), m_val);
            chk("cursor", int'(bus.cursor), m_cur);
            chk("value_valid", int'(bus.value_valid), int'(m_valid));
            chk("changed", int'(bus.changed), int'(m_chg));
            if (bus.changed) chg_total++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // m = {right, left, down, up}
    task automatic btns(logic [3:0] m, int n);
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = m;
        tick(n);
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0;
        tick(20);
    endtask

    task automatic do_load(int v);
        bus.load = 1'b1;
        bus.load_value = 20'(v);
        tick(1);
        bus.load = 1'b0;
        tick(25);
    endtask

    initial begin
        int base, w;
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0;
        bus.load = 1'b0;
        bus.load_value = '0;
        tick(3);
        rst = 1'b0;
        chk("rst_value", int'(bus.value), 1000);
        chk("rst_cursor", int'(bus.cursor), 0);
        chk("rst_valid", int'(bus.value_valid), 1);
        chk("rst_changed", int'(bus.changed), 0);

        base = chg_total;
        for (int i = 0; i < 10; i++) begin
            bus.btn_up = (i % 2 == 0);
            tick(2);
        end
        bus.btn_up = 1'b1;
        tick(10);
        bus.btn_up = 1'b0;
        tick(25);
        chk("bounce_value", int'(bus.value), 1001);
        chk("bounce_commits", chg_total - base, 1);

        repeat (3) btns(4'b0100, 8);
        chk("left3_cursor", int'(bus.cursor), 3);
        btns(4'b0010, 8);
        chk("down_value", int'(bus.value), 1);
        btns(4'b0010, 8);
        chk("down_wrap_value", int'(bus.value), 9001);
        btns(4'b0001, 8);
        chk("up_wrap_value", int'(bus.value), 1);
        repeat (4) btns(4'b1000, 8);
        chk("right_wrap_cursor", int'(bus.cursor), 5);

        do_load(123_456);
        chk("load_value", int'(bus.value), 123_456);
        chk("load_cursor", int'(bus.cursor), 5);
        btns(4'b0100, 8);
        btns(4'b0001, 8);
        chk("load_then_up", int'(bus.value), 123_457);

        do_load(499_999);
        btns(4'b1000, 8);
        base = chg_total;
        btns(4'b0001, 8);
        chk("ceiling_value", int'(bus.value), 499_999);
        chk("ceiling_commits", chg_total - base, 0);
        chk("ceiling_valid", int'(bus.value_valid), 1);

        do_load(1_000_000);
        chk("clamp_value", int'(bus.value), 500_000);
        base = chg_total;
        do_load(500_000);
        chk("same_load_commits", chg_total - base, 1);

        bus.btn_down = 1'b1;
        w = 0;
        while (bus.value_valid && w < 40) begin
            tick(1);
            w++;
        end
        chk("conv_started", int'(bus.value_valid), 0);
        tick(2);
        rst = 1'b1;
        bus.btn_down = 1'b0;
        base = chg_total;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("midconv_rst_value", int'(bus.value), 1000);
        chk("midconv_rst_cursor", int'(bus.cursor), 0);
        chk("midconv_rst_valid", int'(bus.value_valid), 1);
        chk("midconv_rst_commits", chg_total - base, 0);

        base = chg_total;
        bus.btn_up = 1'b1;
        tick(56);
        bus.btn_up = 1'b0;
        tick(30);
        chk("repeat_commits", chg_total - base, 6);
        chk("repeat_value", int'(bus.value), 1006);

        base = chg_total;
        btns(4'b0101, 8);
        chk("prio_value", int'(bus.value), 1007);
        chk("prio_cursor", int'(bus.cursor), 0);
        chk("prio_commits", chg_total - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
